dq_cas_timing_guard: RTL and testbench

//  Parametrised per-bank-group CAS spacing guard on the DQ bus.
//  - Tracks tCCD_S/tCCD_L between same-direction CAS commands.
//  - Tracks read/write turnaround: tWTR_S/tWTR_L for WR->RD and tRTW for RD->WR.
//  - Exposes per-BG, per-direction issue permission to the channel controller's CMD/DQ arbiter.
//  - Flags any CAS acknowledged while its slot was not yet permitted.

---
 rtl/dq_cas_timing_guard.sv | 114 +++++++++++
 tb/tb_dq_cas_timing_guard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dq_cas_timing_guard.sv
// Per-bank-group CAS spacing guard: tracks tCCD_S/L, tWTR_S/L and tRTW on the DQ bus,
// exposes per-BG RD/WR issue permission and flags any CAS issued while not permitted.
module dq_cas_timing_guard #(
    parameter int NUM_BG = 4,
    parameter int T_CCDS = 4,
    parameter int T_CCDL = 6,
    parameter int T_WTRS = 12,
    parameter int T_WTRL = 18,
    parameter int T_RTW  = 8,
    localparam int BG_W  = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cas_issue,
    input  logic              cas_is_wr,
    input  logic [BG_W-1:0]   cas_bg,
    output logic [NUM_BG-1:0] rd_allowed,
    output logic [NUM_BG-1:0] wr_allowed,
    output logic              ccd_violation
);

    localparam int MAX_A   = (T_CCDS > T_CCDL) ? T_CCDS : T_CCDL;
    localparam int MAX_B   = (T_WTRS > T_WTRL) ? T_WTRS : T_WTRL;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T   = (MAX_AB > T_RTW) ? MAX_AB : T_RTW;
    localparam int CNT_W   = $clog2(MAX_T + 1);
    localparam int BG_SPAN = 1 << BG_W;

    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_T);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CCDS = CNT_W'(T_CCDS);
    localparam logic [CNT_W-1:0] C_CCDL = CNT_W'(T_CCDL);
    localparam logic [CNT_W-1:0] C_WTRS = CNT_W'(T_WTRS);
    localparam logic [CNT_W-1:0] C_WTRL = CNT_W'(T_WTRL);
    localparam logic [CNT_W-1:0] C_RTW  = CNT_W'(T_RTW);

    logic [CNT_W-1:0]   e_cnt [NUM_BG];
    logic [NUM_BG-1:0]  w_flag;
    logic [NUM_BG-1:0]  v_flag;
    logic [CNT_W-1:0]   eg_cnt;
    logic               wg_flag;
    logic [BG_W-1:0]    lbg;
    logic               vg_flag;

    logic [BG_SPAN-1:0] bg_map;
    logic [BG_SPAN-1:0] rd_ext;
    logic [BG_SPAN-1:0] wr_ext;
    logic               bg_hit;
    logic               cas_legal;

    // Permission depends only on registered state, never on the current cas_* inputs.
    always_comb begin
        rd_allowed = '0;
        wr_allowed = '0;
        for (int b = 0; b < NUM_BG; b++) begin
            logic same_rd, same_wr, cross_rd, cross_wr, cross_free;
            same_rd    = !v_flag[b] || (e_cnt[b] >= (w_flag[b] ? C_WTRL : C_CCDL));
            same_wr    = !v_flag[b] || (e_cnt[b] >= (w_flag[b] ? C_CCDL : C_RTW));
            cross_free = !vg_flag || (lbg == BG_W'(b));
            cross_rd   = cross_free || (eg_cnt >= (wg_flag ? C_WTRS : C_CCDS));
            cross_wr   = cross_free || (eg_cnt >= (wg_flag ? C_CCDS : C_RTW));
            rd_allowed[b] = same_rd && cross_rd;
            wr_allowed[b] = same_wr && cross_wr;
        end
    end

    // Widen to the full cas_bg code space so out-of-range indices read as illegal.
    always_comb begin
        bg_map = '0;
        bg_map[NUM_BG-1:0] = '1;
        rd_ext = '0;
        rd_ext[NUM_BG-1:0] = rd_allowed;
        wr_ext = '0;
        wr_ext[NUM_BG-1:0] = wr_allowed;
        bg_hit    = cas_issue && bg_map[cas_bg];
        cas_legal = bg_map[cas_bg] && (cas_is_wr ? wr_ext[cas_bg] : rd_ext[cas_bg]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BG; b++) begin
                e_cnt[b] <= C_MAX;
            end
            w_flag        <= '0;
            v_flag        <= '0;
            eg_cnt        <= C_MAX;
            wg_flag       <= 1'b0;
            lbg           <= '0;
            vg_flag       <= 1'b0;
            ccd_violation <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BG; b++) begin
                if (bg_hit && (cas_bg == BG_W'(b))) begin
                    e_cnt[b]  <= C_ONE;
                    w_flag[b] <= cas_is_wr;
                    v_flag[b] <= 1'b1;
                end else if (e_cnt[b] != C_MAX) begin
                    e_cnt[b] <= e_cnt[b] + C_ONE;
                end
            end
            if (bg_hit) begin
                eg_cnt  <= C_ONE;
                wg_flag <= cas_is_wr;
                lbg     <= cas_bg;
                vg_flag <= 1'b1;
            end else if (eg_cnt != C_MAX) begin
                eg_cnt <= eg_cnt + C_ONE;
            end
            // Illegal CAS is reported, never suppressed: state above already took it.
            ccd_violation <= cas_issue && !cas_legal;
        end
    end

endmodule

// File: tb/tb_dq_cas_timing_guard.sv
// Directed bench for dq_cas_timing_guard with hand-computed permission windows
// for the default timing parameters (CCDS 4, CCDL 6, WTRS 12, WTRL 18, RTW 8).
module tb_dq_cas_timing_guard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cas_issue = 1'b0;
    logic       cas_is_wr = 1'b0;
    logic [1:0] cas_bg = 2'd0;
    logic [3:0] rd_allowed;
    logic [3:0] wr_allowed;
    logic       ccd_violation;

    int n_vec = 0;
    int n_err = 0;

    dq_cas_timing_guard dut (
        .clk           (clk),
        .rst           (rst),
        .cas_issue     (cas_issue),
        .cas_is_wr     (cas_is_wr),
        .cas_bg        (cas_bg),
        .rd_allowed    (rd_allowed),
        .wr_allowed    (wr_allowed),
        .ccd_violation (ccd_violation)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one CAS for a single cycle; returns 1 time unit into cycle T+1.
    task automatic issue(input logic wr, input logic [1:0] bg);
        cas_issue = 1'b1;
        cas_is_wr = wr;
        cas_bg    = bg;
        step();
        cas_issue = 1'b0;
        cas_is_wr = 1'($urandom_range(0, 1));
        cas_bg    = 2'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1;
        #2;
        n_vec++;
        if ({rd_allowed, wr_allowed, ccd_violation} !== 9'b1111_1111_0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%b wr=%b viol=%b, want rd=1111 wr=1111 viol=0",
                     rd_allowed, wr_allowed, ccd_violation);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle();
        test_reset();
        for (int k = 0; k < 30; k++) begin
            cas_is_wr = 1'($urandom_range(0, 1));
            cas_bg    = 2'($urandom_range(0, 3));
            step();
            n_vec++;
            if ({rd_allowed, wr_allowed, ccd_violation} !== 9'b1111_1111_0) begin
                n_err++;
                $display("FAIL idle k=%0d: got rd=%b wr=%b viol=%b, want 1111 1111 0",
                         k, rd_allowed, wr_allowed, ccd_violation);
            end
        end
    endtask

    task automatic test_rd_ccd();
        logic [3:0] exp_rd, exp_wr;
        test_reset();
        issue(1'b0, 2'd0);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) step();
            exp_rd = {{3{k >= 4}}, k >= 6};
            exp_wr = {4{k >= 8}};
            n_vec++;
            if (rd_allowed !== exp_rd || wr_allowed !== exp_wr || ccd_violation !== 1'b0) begin
                n_err++;
                $display("FAIL rd_ccd T+%0d: got rd=%b wr=%b viol=%b, want rd=%b wr=%b viol=0",
                         k, rd_allowed, wr_allowed, ccd_violation, exp_rd, exp_wr);
            end
        end
    endtask

    task automatic test_wr_wtr();
        logic [3:0] exp_rd, exp_wr;
        test_reset();
        issue(1'b1, 2'd2);
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) step();
            exp_rd = {k >= 12, k >= 18, k >= 12, k >= 12};
            exp_wr = {k >= 4, k >= 6, k >= 4, k >= 4};
            n_vec++;
            if (rd_allowed !== exp_rd || wr_allowed !== exp_wr) begin
                n_err++;
                $display("FAIL wr_wtr T+%0d: got rd=%b wr=%b, want rd=%b wr=%b",
                         k, rd_allowed, wr_allowed, exp_rd, exp_wr);
            end
        end
    endtask

    task automatic test_rd_rtw();
        logic [3:0] exp_rd, exp_wr;
        test_reset();
        issue(1'b0, 2'd1);
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) step();
            exp_rd = {k >= 4, k >= 4, k >= 6, k >= 4};
            exp_wr = {4{k >= 8}};
            n_vec++;
            if (rd_allowed !== exp_rd || wr_allowed !== exp_wr) begin
                n_err++;
                $display("FAIL rd_rtw T+%0d: got rd=%b wr=%b, want rd=%b wr=%b",
                         k, rd_allowed, wr_allowed, exp_rd, exp_wr);
            end
        end
    endtask

    // RD bg0 at T, RD bg1 at T+4: bg0 reopens at T+8 through the cross rule, not T+6.
    task automatic test_cross_rule();
        test_reset();
        issue(1'b0, 2'd0);
        repeat (3) step();
        issue(1'b0, 2'd1);
        for (int k = 5; k <= 9; k++) begin
            if (k > 5) step();
            n_vec++;
            if (rd_allowed[0] !== (k >= 8) || ccd_violation !== 1'b0) begin
                n_err++;
                $display("FAIL cross_rule T+%0d: got rd0=%b viol=%b, want rd0=%b viol=0",
                         k, rd_allowed[0], ccd_violation, k >= 8);
            end
        end
    endtask

    // Illegal RD bg0 two cycles after RD bg0: flagged once, and it still restarts the window.
    task automatic test_violation();
        logic exp_v;
        test_reset();
        issue(1'b0, 2'd0);
        step();
        issue(1'b0, 2'd0);
        for (int k = 3; k <= 9; k++) begin
            if (k > 3) step();
            exp_v = (k == 3);
            n_vec++;
            if (ccd_violation !== exp_v || rd_allowed[0] !== (k >= 8)) begin
                n_err++;
                $display("FAIL violation T+%0d: got viol=%b rd0=%b, want viol=%b rd0=%b",
                         k, ccd_violation, rd_allowed[0], exp_v, k >= 8);
            end
        end
    endtask

    // WR bg0 at T, WR bg1 at T+1: second is illegal, latest issue reloads the global window.
    task automatic test_back_to_back();
        logic [1:0] exp_w;
        test_reset();
        issue(1'b1, 2'd0);
        issue(1'b1, 2'd1);
        n_vec++;
        if (ccd_violation !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_viol: got viol=%b, want 1", ccd_violation);
        end
        for (int k = 3; k <= 8; k++) begin
            step();
            exp_w = {k >= 7, k >= 6};
            n_vec++;
            if (wr_allowed[1:0] !== exp_w || ccd_violation !== 1'b0) begin
                n_err++;
                $display("FAIL b2b T+%0d: got wr[1:0]=%b viol=%b, want wr[1:0]=%b viol=0",
                         k, wr_allowed[1:0], ccd_violation, exp_w);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        test_reset();
        issue(1'b1, 2'd0);
        step();
        n_vec++;
        if (wr_allowed[0] !== 1'b0 || rd_allowed !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_pre: got rd=%b wr0=%b, want rd=0000 wr0=0", rd_allowed, wr_allowed[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (rd_allowed !== 4'b1111 || wr_allowed !== 4'b1111) begin
            n_err++;
            $display("FAIL mid_after_rst: got rd=%b wr=%b, want 1111 1111", rd_allowed, wr_allowed);
        end
        issue(1'b1, 2'd0);
        n_vec++;
        if (ccd_violation !== 1'b0) begin
            n_err++;
            $display("FAIL mid_issue: got viol=%b, want 0", ccd_violation);
        end
    endtask

    initial begin
        rst = 1'b1;
        #12;
        rst = 1'b0;
        test_reset();
        test_idle();
        test_rd_ccd();
        test_wr_wtr();
        test_rd_rtw();
        test_cross_rule();
        test_violation();
        test_back_to_back();
        test_reset_mid_window();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
